bus_assign_scheduler: RTL

BUS_ASSIGN_SCHEDULER -- requirements
Module: bus_assign_scheduler

---
 rtl/bus_assign_pkg.sv | 15 +
 rtl/bus_assign_req_check.sv | 34 +++
 rtl/bus_assign_scheduler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/bus_assign_pkg.sv
// Shared types and helpers for the bus-assign scheduler slice.
package bus_assign_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    DONE
  } state_e;

  // Slice-index width for a bus of the given width, never below one bit.
  function automatic int unsigned idx_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bus_assign_req_check.sv
// Combinational validator for an assign request's sink and source slices.
module bus_assign_req_check
  import bus_assign_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IW    = idx_width(WIDTH)
) (
  input  logic [IW-1:0] dst_msb,
  input  logic [IW-1:0] dst_lsb,
  input  logic [IW-1:0] src_msb,
  input  logic [IW-1:0] src_lsb,
  output logic          range_err,
  output logic          step_err
);

  localparam logic [IW:0] LIMIT = (IW+1)'(WIDTH);

  logic [IW:0] dm, dl, sm, sl;
  logic [IW:0] dst_span, src_span;

  // Range check first; a step mismatch only counts when every index is legal.
  always_comb begin
    dm        = {1'b0, dst_msb};
    dl        = {1'b0, dst_lsb};
    sm        = {1'b0, src_msb};
    sl        = {1'b0, src_lsb};
    range_err = (dm >= LIMIT) || (dl >= LIMIT) || (sm >= LIMIT) || (sl >= LIMIT) ||
                (dm < dl) || (sm < sl);
    dst_span  = dm - dl;
    src_span  = sm - sl;
    step_err  = !range_err && (dst_span != src_span);
  end

endmodule

// File: rtl/bus_assign_scheduler.sv
// Copies a source-bus slice into a registered sink bus one bit per cycle.
module bus_assign_scheduler
  import bus_assign_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IW    = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IW-1:0]    req_dst_msb,
  input  logic [IW-1:0]    req_dst_lsb,
  input  logic [IW-1:0]    req_src_msb,
  input  logic [IW-1:0]    req_src_lsb,
  input  logic             clear,
  input  logic [WIDTH-1:0] source_bus,
  output logic [WIDTH-1:0] sink_bus,
  output logic [WIDTH-1:0] driven_mask,
  output logic             busy,
  output logic             done,
  output logic             conflict,
  output logic             err_step,
  output logic             err_range
);

  state_e           state_q, state_d;
  logic [IW-1:0]    dst_msb_q, dst_msb_d, dst_lsb_q, dst_lsb_d;
  logic [IW-1:0]    src_msb_q, src_msb_d, src_lsb_q, src_lsb_d;
  logic [IW:0]      k_q, k_d;
  logic [WIDTH-1:0] sink_q, sink_d, mask_q, mask_d;
  logic             conflict_q, conflict_d;
  logic             done_q, done_d;
  logic             err_step_q, err_step_d;
  logic             err_range_q, err_range_d;

  logic             range_err, step_err;
  logic [IW:0]      wr_idx, rd_idx;
  logic             src_bit, last;

  bus_assign_req_check #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_req_check (
    .dst_msb   (req_dst_msb),
    .dst_lsb   (req_dst_lsb),
    .src_msb   (req_src_msb),
    .src_lsb   (req_src_lsb),
    .range_err (range_err),
    .step_err  (step_err)
  );

  // Next-state, copy datapath and pulse generation; clear overrides every state.
  always_comb begin
    state_d     = state_q;
    dst_msb_d   = dst_msb_q;
    dst_lsb_d   = dst_lsb_q;
    src_msb_d   = src_msb_q;
    src_lsb_d   = src_lsb_q;
    k_d         = k_q;
    sink_d      = sink_q;
    mask_d      = mask_q;
    conflict_d  = conflict_q;
    done_d      = 1'b0;
    err_step_d  = 1'b0;
    err_range_d = 1'b0;
    req_ready   = (state_q == IDLE) && !clear;

    wr_idx  = {1'b0, dst_lsb_q} + k_q;
    rd_idx  = {1'b0, src_lsb_q} + k_q;
    // Both slices have equal span, so they end on the same cycle.
    last    = (wr_idx == {1'b0, dst_msb_q}) || (rd_idx == {1'b0, src_msb_q});
    src_bit = 1'b0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      if (rd_idx == (IW+1)'(j)) src_bit = source_bus[j];
    end

    if (clear) begin
      state_d    = IDLE;
      sink_d     = '0;
      mask_d     = '0;
      conflict_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            dst_msb_d = req_dst_msb;
            dst_lsb_d = req_dst_lsb;
            src_msb_d = req_src_msb;
            src_lsb_d = req_src_lsb;
            if (range_err) begin
              err_range_d = 1'b1;
            end else if (step_err) begin
              err_step_d = 1'b1;
            end else begin
              state_d = COPY;
              k_d     = '0;
            end
          end
        end
        COPY: begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (wr_idx == (IW+1)'(i)) begin
              if (mask_q[i]) conflict_d = 1'b1;
              sink_d[i] = src_bit;
              mask_d[i] = 1'b1;
            end
          end
          k_d = k_q + 1'b1;
          if (last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dst_msb_q   <= '0;
      dst_lsb_q   <= '0;
      src_msb_q   <= '0;
      src_lsb_q   <= '0;
      k_q         <= '0;
      sink_q      <= '0;
      mask_q      <= '0;
      conflict_q  <= 1'b0;
      done_q      <= 1'b0;
      err_step_q  <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dst_msb_q   <= dst_msb_d;
      dst_lsb_q   <= dst_lsb_d;
      src_msb_q   <= src_msb_d;
      src_lsb_q   <= src_lsb_d;
      k_q         <= k_d;
      sink_q      <= sink_d;
      mask_q      <= mask_d;
      conflict_q  <= conflict_d;
      done_q      <= done_d;
      err_step_q  <= err_step_d;
      err_range_q <= err_range_d;
    end
  end

  assign sink_bus    = sink_q;
  assign driven_mask = mask_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign conflict    = conflict_q;
  assign err_step    = err_step_q;
  assign err_range   = err_range_q;

endmodule
